// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: hazard FSM states, stall/flush control bundle,
// ID/EX bubble constants and the load-use hazard check.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hsu_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_stall;
    } stall_ctrl_t;

    localparam stall_ctrl_t CTRL_NONE = '0;
    localparam stall_ctrl_t CTRL_MEM_HOLD = '{
        pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
        idex_bubble: 1'b0, exmem_stall: 1'b1
    };
    localparam stall_ctrl_t CTRL_MISPREDICT = '{
        pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1,
        idex_bubble: 1'b1, exmem_stall: 1'b0
    };
    localparam stall_ctrl_t CTRL_LOAD_USE = '{
        pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
        idex_bubble: 1'b1, exmem_stall: 1'b0
    };

    // Control word held in ID/EX; a bubble zeroes all of it.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t  IDEX_CTRL_NOP = '0;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_uses_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module hazard_stall_unit_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use bubble, memory-wait hold and mispredict flush control for the
// ID/EX side of the pipeline, with a memory-wait watchdog and stall statistic.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RegWriteAddr,
    input  logic             EX_mispredict,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             IFID_stall,
    output logic             IFID_flush,
    output logic             IDEX_bubble,
    output logic             EXMEM_stall,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    hsu_state_t  r_state;
    hsu_state_t  w_state_nxt;
    logic        r_err;
    logic        r_wd_block;
    logic        w_load_use;
    logic        w_mem_busy;
    logic        w_timeout;
    logic        w_wait_en;
    logic        w_wait_clr;
    logic [WC_W-1:0] w_wait_cnt;
    stall_ctrl_t w_ctrl;

    assign w_load_use = load_use_hazard(EX_MemRead, EX_RegWriteAddr,
                                        ID_rs1, ID_rs2, ID_uses_rs2);

    // After a watchdog abort the same request is ignored until dmem_req drops.
    assign w_mem_busy = dmem_req && !dmem_ready && !r_wd_block;

    assign w_timeout  = (r_state == ST_MEM_WAIT) && w_mem_busy &&
                        (w_wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    assign w_wait_en  = (r_state == ST_MEM_WAIT) && w_mem_busy;
    assign w_wait_clr = rst || (r_state == ST_RUN) || w_timeout;

    always_comb begin
        w_ctrl      = CTRL_NONE;
        w_state_nxt = r_state;
        if (rst) begin
            w_state_nxt = ST_RUN;
        end else if (w_mem_busy) begin
            w_ctrl      = CTRL_MEM_HOLD;
            w_state_nxt = w_timeout ? ST_RUN : ST_MEM_WAIT;
        end else begin
            w_state_nxt = ST_RUN;
            if (EX_mispredict) begin
                w_ctrl = CTRL_MISPREDICT;
            end else if (w_load_use) begin
                w_ctrl = CTRL_LOAD_USE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_err      <= 1'b0;
            r_wd_block <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_timeout) begin
                r_err      <= 1'b1;
                r_wd_block <= 1'b1;
            end else if (!dmem_req) begin
                r_wd_block <= 1'b0;
            end
        end
    end

    hazard_stall_unit_sat_counter #(
        .W (WC_W)
    ) u_wait_cnt (
        .clk     (clk),
        .i_clr   (w_wait_clr),
        .i_en    (w_wait_en),
        .o_count (w_wait_cnt)
    );

    hazard_stall_unit_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clr   (rst),
        .i_en    (w_ctrl.pc_stall),
        .o_count (stall_cycles)
    );

    assign pc_stall        = w_ctrl.pc_stall;
    assign IFID_stall      = w_ctrl.ifid_stall;
    assign IFID_flush      = w_ctrl.ifid_flush;
    assign IDEX_bubble     = w_ctrl.idex_bubble;
    assign EXMEM_stall     = w_ctrl.exmem_stall;
    assign mem_timeout_err = r_err;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit against a cycle-level
// reference model; two instances cover the wide and a 3-bit stall counter.
module tb_hazard_stall_unit;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs1, ID_rs2, EX_RegWriteAddr;
    logic       ID_uses_rs2, EX_MemRead, EX_mispredict, dmem_req, dmem_ready;

    logic        pc_a, ifs_a, iff_a, bub_a, exs_a, err_a;
    logic [15:0] cnt_a;
    logic        pc_b, ifs_b, iff_b, bub_b, exs_b, err_b;
    logic [2:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit     m_in_wait, m_err, m_blocked;
    int     m_waited;
    longint m_stalls;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs2(ID_uses_rs2), .EX_MemRead(EX_MemRead),
        .EX_RegWriteAddr(EX_RegWriteAddr), .EX_mispredict(EX_mispredict),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_a), .IFID_stall(ifs_a), .IFID_flush(iff_a),
        .IDEX_bubble(bub_a), .EXMEM_stall(exs_a),
        .mem_timeout_err(err_a), .stall_cycles(cnt_a)
    );

    hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_uses_rs2(ID_uses_rs2), .EX_MemRead(EX_MemRead),
        .EX_RegWriteAddr(EX_RegWriteAddr), .EX_mispredict(EX_mispredict),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_b), .IFID_stall(ifs_b), .IFID_flush(iff_b),
        .IDEX_bubble(bub_b), .EXMEM_stall(exs_b),
        .mem_timeout_err(err_b), .stall_cycles(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_to(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    // Inputs are already applied; check this cycle, then advance the model.
    task automatic step();
        bit         busy, lu;
        logic [4:0] exp_v;
        #1;
        lu   = EX_MemRead && (EX_RegWriteAddr != 0) &&
               ((EX_RegWriteAddr == ID_rs1) || (ID_uses_rs2 && (EX_RegWriteAddr == ID_rs2)));
        busy = dmem_req && !dmem_ready && !m_blocked;
        // {pc_stall, IFID_stall, IFID_flush, IDEX_bubble, EXMEM_stall}
        exp_v = 5'b00000;
        if (!rst) begin
            if (busy)               exp_v = 5'b11001;
            else if (EX_mispredict) exp_v = 5'b00110;
            else if (lu)            exp_v = 5'b11010;
        end
        check("ctrl_a", {27'd0, pc_a, ifs_a, iff_a, bub_a, exs_a}, {27'd0, exp_v});
        check("ctrl_b", {27'd0, pc_b, ifs_b, iff_b, bub_b, exs_b}, {27'd0, exp_v});
        check("err_a", {31'd0, err_a}, {31'd0, m_err});
        check("err_b", {31'd0, err_b}, {31'd0, m_err});
        check("stall_cycles_a", {16'd0, cnt_a}, sat_to(m_stalls, 16));
        check("stall_cycles_b", {29'd0, cnt_b}, sat_to(m_stalls, 3));

        if (rst) begin
            m_in_wait = 0; m_waited = 0; m_err = 0; m_blocked = 0; m_stalls = 0;
        end else begin
            if (exp_v[4]) m_stalls++;
            if (busy) begin
                if (m_in_wait) begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_err = 1; m_blocked = 1; m_in_wait = 0; m_waited = 0;
                    end
                end else begin
                    m_in_wait = 1;
                end
            end else begin
                m_in_wait = 0;
                m_waited  = 0;
                if (!dmem_req) m_blocked = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input int rs1, input int rs2, input bit u2,
                         input bit mr, input int rd, input bit mis,
                         input bit rq, input bit rdy);
        rst = r; ID_rs1 = 5'(rs1); ID_rs2 = 5'(rs2); ID_uses_rs2 = u2;
        EX_MemRead = mr; EX_RegWriteAddr = 5'(rd); EX_mispredict = mis;
        dmem_req = rq; dmem_ready = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
    endtask

    initial begin
        int ready_pct;
        m_in_wait = 0; m_err = 0; m_blocked = 0; m_waited = 0; m_stalls = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        drive(1, 5, 5, 1, 1, 5, 1, 1, 0);   // reset must mask every stall source
        step();
        idle(1);

        // load-use on rs1, then bubble clears EX_MemRead
        drive(0, 5, 7, 1, 1, 5, 0, 0, 0); step();
        drive(0, 6, 5, 1, 0, 0, 0, 0, 0); step();
        // x0 destination and unused rs2 never stall
        drive(0, 0, 3, 1, 1, 0, 0, 0, 0); step();
        drive(0, 1, 9, 0, 1, 9, 0, 0, 0); step();
        drive(0, 1, 9, 1, 1, 9, 0, 0, 0); step();
        idle(1);

        // three busy cycles then ready
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        idle(1);

        // mispredict beats load-use; mispredict held through a memory wait
        drive(0, 5, 0, 0, 1, 5, 1, 0, 0); step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1); step();
        idle(1);

        // watchdog: ready stuck low, then req drops, then reset clears err
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        end
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        idle(1);

        // ten stall cycles: 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            drive(0, 3, 0, 0, 1, 3, 0, 0, 0); step();
        end
        idle(2);

        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) ready_pct = (ready_pct == 50) ? 5 : 50;
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 99) < ready_pct);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
